pipelined_decode_unit: RTL

PIPELINED_DECODE_UNIT -- requirements
Module: pipelined_decode_unit

---
 rtl/decode_pkg.sv | 29 ++
 rtl/decode_regfile.sv | 65 ++++++
 rtl/pipelined_decode_unit.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/decode_pkg.sv
// Shared definitions for the decode stage: instruction field positions, immediate widths,
// default control-bundle parameters and the bubble control value.
package decode_pkg;

  localparam int unsigned CondHi = 31;
  localparam int unsigned CondLo = 28;
  localparam int unsigned OpHi   = 27;
  localparam int unsigned OpLo   = 24;
  localparam int unsigned RnHi   = 19;
  localparam int unsigned RnLo   = 16;
  localparam int unsigned RdHi   = 15;
  localparam int unsigned RdLo   = 12;
  localparam int unsigned RmHi   = 3;
  localparam int unsigned RmLo   = 0;

  localparam int unsigned BrImmW  = 24;
  localparam int unsigned LsImmW  = 12;
  localparam int unsigned AluImmW = 8;

  localparam int unsigned DefSigW    = 11;
  localparam int unsigned DefLoadBit = 6;

  localparam int unsigned RegIdxW = 4;
  typedef logic [RegIdxW-1:0] reg_idx_t;

  // A bubble carries no control: every signal deasserted.
  localparam logic [DefSigW-1:0] BubbleSig = '0;

endpackage

// File: rtl/decode_regfile.sv
// Decode-stage register file: two asynchronous read ports, one synchronous write port.
// Indices at or above NREGS read as zero and are never written. DECODE_BYPASS_EN adds write-through.
module decode_regfile
  import decode_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned NREGS  = 16
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  reg_idx_t          ra_i,
  input  reg_idx_t          rb_i,
  output logic [DATA_W-1:0] da_o,
  output logic [DATA_W-1:0] db_o,
  input  logic              we_i,
  input  reg_idx_t          wa_i,
  input  logic [DATA_W-1:0] wd_i
);

  logic [DATA_W-1:0] rf_q [NREGS];
  logic [DATA_W-1:0] rf_d [NREGS];

  // Out-of-range indices match no entry, so writes drop and reads fall through to zero.
  always_comb begin
    rf_d = rf_q;
    for (int unsigned i = 0; i < NREGS; i++) begin
      if (we_i && (wa_i == i[RegIdxW-1:0])) begin
        rf_d[i] = wd_i;
      end
    end
  end

  always_comb begin
    da_o = '0;
    db_o = '0;
    for (int unsigned i = 0; i < NREGS; i++) begin
`ifdef DECODE_BYPASS_EN
      if (ra_i == i[RegIdxW-1:0]) begin
        da_o = (we_i && (wa_i == ra_i)) ? wd_i : rf_q[i];
      end
      if (rb_i == i[RegIdxW-1:0]) begin
        db_o = (we_i && (wa_i == rb_i)) ? wd_i : rf_q[i];
      end
`else
      if (ra_i == i[RegIdxW-1:0]) begin
        da_o = rf_q[i];
      end
      if (rb_i == i[RegIdxW-1:0]) begin
        db_o = rf_q[i];
      end
`endif
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        rf_q[i] <= '0;
      end
    end else begin
      rf_q <= rf_d;
    end
  end

endmodule

// File: rtl/pipelined_decode_unit.sv
// Decode stage: splits the instruction, reads operands, builds immediates and latches them
// behind a valid/ready handshake with one-bubble load-use stalls. DECODE_BYPASS_EN: write-through.
module pipelined_decode_unit
  import decode_pkg::*;
#(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned NREGS    = 16,
  parameter int unsigned SIG_W    = DefSigW,
  parameter int unsigned LOAD_BIT = DefLoadBit
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [31:0]        instruction,
  input  logic [31:0]        pc_in,
  input  logic [SIG_W-1:0]   ctrl_in,
  input  logic               flush,
  input  logic               wb_en,
  input  logic [RegIdxW-1:0] wb_rd,
  input  logic [DATA_W-1:0]  wb_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  pc_out,
  output logic [DATA_W-1:0]  dataA_out,
  output logic [DATA_W-1:0]  dataB_out,
  output logic [DATA_W-1:0]  br_se_out,
  output logic [DATA_W-1:0]  ls_se_out,
  output logic [DATA_W-1:0]  alu_se_out,
  output logic [3:0]         rd_out,
  output logic [3:0]         rn_out,
  output logic [3:0]         rm_out,
  output logic [3:0]         br_cond,
  output logic [SIG_W-1:0]   signals_out,
  output logic               hazard_stall
);

  typedef struct packed {
    logic [DATA_W-1:0] pc;
    logic [DATA_W-1:0] data_a;
    logic [DATA_W-1:0] data_b;
    logic [DATA_W-1:0] br_se;
    logic [DATA_W-1:0] ls_se;
    logic [DATA_W-1:0] alu_se;
    reg_idx_t          rd;
    reg_idx_t          rn;
    reg_idx_t          rm;
    logic [3:0]        cond;
    logic [SIG_W-1:0]  sig;
  } latch_t;

  reg_idx_t          rn, rd, rm;
  logic [3:0]        cond;
  logic [BrImmW-1:0] imm;
  logic              unused_op;

  assign cond      = instruction[CondHi:CondLo];
  assign rn        = instruction[RnHi:RnLo];
  assign rd        = instruction[RdHi:RdLo];
  assign rm        = instruction[RmHi:RmLo];
  assign imm       = instruction[BrImmW-1:0];
  assign unused_op = ^instruction[OpHi:OpLo];

  logic [DATA_W-1:0] rf_a, rf_b;

  decode_regfile #(
    .DATA_W(DATA_W),
    .NREGS (NREGS)
  ) u_regfile (
    .clk_i (clk),
    .rst_ni(reset),
    .ra_i  (rn),
    .rb_i  (rm),
    .da_o  (rf_a),
    .db_o  (rf_b),
    .we_i  (wb_en),
    .wa_i  (wb_rd),
    .wd_i  (wb_data)
  );

  logic   valid_q, valid_d;
  latch_t lat_q, lat_d, lat_in;
  logic   hazard, accept;

  // Load in the latch whose destination feeds the waiting instruction.
  assign hazard   = valid_q && lat_q.sig[LOAD_BIT] && in_valid &&
                    ((lat_q.rd == rn) || (lat_q.rd == rm));
  assign in_ready = (!valid_q || out_ready) && !hazard;
  assign accept   = in_valid && in_ready;

  always_comb begin
    lat_in.pc     = DATA_W'(pc_in);
    lat_in.data_a = rf_a;
    lat_in.data_b = rf_b;
    lat_in.br_se  = DATA_W'($signed(imm)) << 2;
    lat_in.ls_se  = DATA_W'(imm[LsImmW-1:0]);
    lat_in.alu_se = DATA_W'(imm[AluImmW-1:0]);
    lat_in.rd     = rd;
    lat_in.rn     = rn;
    lat_in.rm     = rm;
    lat_in.cond   = cond;
    lat_in.sig    = ctrl_in;
  end

  always_comb begin
    valid_d = valid_q;
    lat_d   = lat_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (hazard && out_ready) begin
      valid_d   = 1'b0;
      lat_d.sig = SIG_W'(BubbleSig);
    end else if (accept) begin
      valid_d = 1'b1;
      lat_d   = lat_in;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= 1'b0;
      lat_q   <= '0;
    end else begin
      valid_q <= valid_d;
      lat_q   <= lat_d;
    end
  end

  assign out_valid    = valid_q;
  assign pc_out       = lat_q.pc;
  assign dataA_out    = lat_q.data_a;
  assign dataB_out    = lat_q.data_b;
  assign br_se_out    = lat_q.br_se;
  assign ls_se_out    = lat_q.ls_se;
  assign alu_se_out   = lat_q.alu_se;
  assign rd_out       = lat_q.rd;
  assign rn_out       = lat_q.rn;
  assign rm_out       = lat_q.rm;
  assign br_cond      = lat_q.cond;
  assign signals_out  = lat_q.sig;
  assign hazard_stall = hazard;

endmodule
